// File: rtl/tron_fb_pkg.sv
// Shared frame-buffer geometry, types and word-packing helpers for the trail writer slice.
package tron_fb_pkg;

  localparam int unsigned H_RES          = 640;
  localparam int unsigned V_RES          = 480;
  localparam int unsigned WORDS_PER_LINE = 320;
  localparam int unsigned FB_WORDS       = 153600;

  typedef logic [3:0] color_enum_t;

  typedef enum logic [1:0] {IDLE, CLEAR, PLOT} tw_state_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    color_enum_t color;
  } plot_req_t;

  function automatic logic [15:0] pack_word(input color_enum_t c);
    return {4'h0, c, 4'h0, c};
  endfunction

  // Word index of a 2-pixel cell: xw + y*320, with y*320 built as (y<<8)+(y<<6).
  function automatic logic [18:0] plot_addr(input logic [8:0] xw, input logic [9:0] y);
    return 19'(xw) + (19'(y) << 8) + (19'(y) << 6);
  endfunction

endpackage

// File: rtl/trail_writer_if.sv
// Plot/clear request and frameRAM write bundle; slave = trail_writer, master = requester.
// Drop_Count exists only when FB_BOUNDS_CHECK_EN is defined.
interface trail_writer_if;
  import tron_fb_pkg::*;

  logic        Clear_Req;
  color_enum_t Clear_Color;
  logic        Plot_Valid;
  logic        Plot_Ready;
  logic [9:0]  Plot_X;
  logic [9:0]  Plot_Y;
  color_enum_t Plot_Color;
  logic [18:0] write_address;
  logic [15:0] Data_In;
  logic        WE;
  logic        Busy;
`ifdef FB_BOUNDS_CHECK_EN
  logic [7:0]  Drop_Count;
`endif

  modport slave (
    input  Clear_Req, Clear_Color, Plot_Valid, Plot_X, Plot_Y, Plot_Color,
    output Plot_Ready, write_address, Data_In, WE, Busy
`ifdef FB_BOUNDS_CHECK_EN
    , output Drop_Count
`endif
  );

  modport master (
    output Clear_Req, Clear_Color, Plot_Valid, Plot_X, Plot_Y, Plot_Color,
    input  Plot_Ready, write_address, Data_In, WE, Busy
`ifdef FB_BOUNDS_CHECK_EN
    , input Drop_Count
`endif
  );

endinterface

// File: rtl/plot_fifo.sv
// Synchronous FIFO for plot requests; DEPTH must be a power of two >= 2.
module plot_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/trail_writer.sv
// Frame-buffer write side: full-screen clear and buffered bike-trail plots, one write per cycle.
// Optional FB_BOUNDS_CHECK_EN drops out-of-range plots at pop and counts them in Drop_Count.
module trail_writer
  import tron_fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CLEAR_WORDS = FB_WORDS
) (
  input logic           Clk,
  input logic           Reset_n,
  trail_writer_if.slave bus
);

  localparam logic [17:0] CLR_LAST = 18'(CLEAR_WORDS - 1);

  tw_state_t   state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  color_enum_t clr_col_q, clr_col_d;
  logic        clr_pend_q, clr_pend_d;
  logic        we_q, we_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;

  plot_req_t push_req, head;
  logic      fifo_full, fifo_empty, push, pop;
  logic      in_range, drop_inc;
  logic      unused_x0;

  assign push_req = '{x: bus.Plot_X, y: bus.Plot_Y, color: bus.Plot_Color};
  assign push     = bus.Plot_Valid && !fifo_full;
  assign unused_x0 = head.x[0];

  plot_fifo #(
    .WIDTH ($bits(plot_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .push_i  (push),
    .din_i   (push_req),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef FB_BOUNDS_CHECK_EN
  logic [7:0] drop_q;

  assign in_range = (int unsigned'(head.x) < H_RES) && (int unsigned'(head.y) < V_RES);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                      drop_q <= '0;
    else if (drop_inc && drop_q != '1) drop_q <= drop_q + 8'd1;
  end

  assign bus.Drop_Count = drop_q;
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_col_d  = clr_col_q;
    clr_pend_d = clr_pend_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    pop        = 1'b0;
    drop_inc   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Clear_Req) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          clr_col_d  = bus.Clear_Color;
          clr_pend_d = 1'b0;
        end else if (clr_pend_q) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          clr_pend_d = 1'b0;
        end else if (!fifo_empty) begin
          state_d = PLOT;
        end
      end

      CLEAR: begin
        we_d   = 1'b1;
        addr_d = 19'(cnt_q);
        data_d = pack_word(clr_col_q);
        if (cnt_q == CLR_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 18'd1;
      end

      PLOT: begin
        // A clear pulse arriving mid-plot is latched so the detour through IDLE cannot lose it.
        if (bus.Clear_Req) begin
          state_d    = IDLE;
          clr_pend_d = 1'b1;
          clr_col_d  = bus.Clear_Color;
        end else if (fifo_empty) begin
          state_d = IDLE;
        end else begin
          pop = 1'b1;
          if (in_range) begin
            we_d   = 1'b1;
            addr_d = plot_addr(head.x[9:1], head.y);
            data_d = pack_word(head.color);
          end else begin
            drop_inc = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_col_q  <= '0;
      clr_pend_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_col_q  <= clr_col_d;
      clr_pend_q <= clr_pend_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign bus.Plot_Ready    = !fifo_full;
  assign bus.WE            = we_q;
  assign bus.write_address = addr_q;
  assign bus.Data_In       = data_q;
  assign bus.Busy          = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_trail_writer.sv
// Scoreboard bench for trail_writer: expected frameRAM writes are queued at stimulus time
// and popped by a negedge monitor; a shortened clear length keeps runtime small.
module tb_trail_writer;
  import tron_fb_pkg::*;

  localparam int unsigned CW = 2048;

  typedef struct {
    logic [18:0] a;
    logic [15:0] d;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 Clk = ~Clk;

  trail_writer_if bus ();

  trail_writer #(
    .FIFO_DEPTH  (4),
    .CLEAR_WORDS (CW)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always @(negedge Clk) begin
    if (Reset_n && bus.WE) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %h, required no write",
                 bus.write_address, bus.Data_In);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.write_address !== mon_e.a || bus.Data_In !== mon_e.d) begin
          n_fail++;
          $display("FAIL write: addr %0d data %h, required addr %0d data %h",
                   bus.write_address, bus.Data_In, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input int unsigned a, input logic [15:0] d);
    exp_t e;
    e.a = 19'(a);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_clear(input int unsigned n, input logic [3:0] c);
    for (int unsigned i = 0; i < n; i++) expect_write(i, {4'h0, c, 4'h0, c});
  endtask

  task automatic plot(input int unsigned x, input int unsigned y, input logic [3:0] c);
    bus.Plot_X     = 10'(x);
    bus.Plot_Y     = 10'(y);
    bus.Plot_Color = c;
    bus.Plot_Valid = 1'b1;
    tick();
    bus.Plot_Valid = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned budget, input string name);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || bus.Busy) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size() == 0 && !bus.Busy), 32'd1);
  endtask

  initial begin
    int unsigned run;
    bus.Clear_Req   = 1'b0;
    bus.Clear_Color = '0;
    bus.Plot_Valid  = 1'b0;
    bus.Plot_X      = '0;
    bus.Plot_Y      = '0;
    bus.Plot_Color  = '0;

    repeat (3) tick();
    chk("rst_we",    32'(bus.WE),            32'd0);
    chk("rst_addr",  32'(bus.write_address), 32'd0);
    chk("rst_data",  32'(bus.Data_In),       32'd0);
    chk("rst_busy",  32'(bus.Busy),          32'd0);
    chk("rst_ready", 32'(bus.Plot_Ready),    32'd1);
    Reset_n = 1'b1;
    repeat (2) tick();

    // Plot (3,0,4): accepted at edge n, written at edge n+2 for exactly one cycle.
    expect_write(1, 16'h0404);
    plot(3, 0, 4'h4);
    chk("lat_n0_we", 32'(bus.WE), 32'd0);
    tick();
    chk("lat_n1_we", 32'(bus.WE), 32'd0);
    tick();
    chk("lat_n2_we", 32'(bus.WE), 32'd1);
    tick();
    chk("lat_n3_we", 32'(bus.WE), 32'd0);
    repeat (2) tick();

    // Bottom-right corner maps to the last word; Busy falls one cycle after the write.
    expect_write(153599, 16'h0808);
    plot(639, 479, 4'h8);
    repeat (2) tick();
    chk("corner_we",   32'(bus.WE),   32'd1);
    chk("corner_busy", 32'(bus.Busy), 32'd1);
    tick();
    chk("corner_busy_drop", 32'(bus.Busy), 32'd0);
    repeat (2) tick();

    // Clear col 0: WE must stay high for exactly CW consecutive cycles.
    expect_clear(CW, 4'h0);
    bus.Clear_Color = 4'h0;
    bus.Clear_Req   = 1'b1;
    tick();
    bus.Clear_Req = 1'b0;
    chk("clr_we_start", 32'(bus.WE), 32'd0);
    run = 0;
    for (int unsigned i = 0; i < CW + 10; i++) begin
      tick();
      if (bus.WE) run++;
      else break;
    end
    chk("clr_run_len",   run,                  CW);
    chk("clr_busy_done", 32'(bus.Busy),        32'd0);
    chk("clr_q_empty",   32'(exp_q.size()),    32'd0);
    repeat (2) tick();

    // Five plots during a clear: the fifth is refused, the four run after the clear in order.
    expect_clear(CW, 4'hA);
    bus.Clear_Color = 4'hA;
    bus.Clear_Req   = 1'b1;
    tick();
    bus.Clear_Req = 1'b0;
    expect_write(641, 16'h0101);
    expect_write(642, 16'h0202);
    expect_write(643, 16'h0303);
    expect_write(644, 16'h0505);
    for (int unsigned k = 0; k < 5; k++) begin
      bus.Plot_X     = 10'(2 + 2 * k);
      bus.Plot_Y     = 10'd2;
      bus.Plot_Color = (k == 3) ? 4'h5 : (k == 4) ? 4'h6 : 4'(k + 1);
      bus.Plot_Valid = 1'b1;
      #1;
      chk($sformatf("fill_ready_%0d", k), 32'(bus.Plot_Ready), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    bus.Plot_Valid = 1'b0;
    wait_drain(CW + 100, "fill_drain");
    repeat (2) tick();

    // Clear and plot in the same cycle: clear first, plot written right after the last clear word.
    expect_clear(CW, 4'h9);
    expect_write(325, 16'h0707);
    bus.Clear_Color = 4'h9;
    bus.Clear_Req   = 1'b1;
    plot(10, 1, 4'h7);
    bus.Clear_Req = 1'b0;
    wait_drain(CW + 100, "simul_drain");
    repeat (2) tick();

    // Reset at clear word 1000 aborts the clear and discards a pending plot.
    expect_clear(1000, 4'h3);
    bus.Clear_Color = 4'h3;
    bus.Clear_Req   = 1'b1;
    tick();
    bus.Clear_Req = 1'b0;
    plot(20, 3, 4'h2);
    repeat (999) tick();
    @(negedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("abort_we",    32'(bus.WE),          32'd0);
    chk("abort_busy",  32'(bus.Busy),        32'd0);
    chk("abort_ready", 32'(bus.Plot_Ready),  32'd1);
    chk("abort_q",     32'(exp_q.size()),    32'd0);
    repeat (2) tick();
    Reset_n = 1'b1;
    run = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      if (bus.WE) run++;
    end
    chk("post_reset_writes", run, 32'd0);

`ifdef FB_BOUNDS_CHECK_EN
    plot(640, 0, 4'h1);
    repeat (5) tick();
    chk("drop_count", 32'(bus.Drop_Count), 32'd1);
    chk("drop_busy",  32'(bus.Busy),       32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
